// File: rtl/pyramic_clkgen_nco.sv
`default_nettype none
// ============================================================================
//  Module   : pyramic_clkgen_nco
//  Purpose  : Phase-accumulator NCO that produces a base tick from refclk and
//             derives NUM_OUT 50%-duty clocks from it through per-output
//             integer dividers. The clock is reported as locked after a fixed
//             settle time. New increment/divisor sets arrive through a
//             valid/ready handshake and are applied atomically in a one-cycle
//             UPDATE state, which then re-runs the settle time.
//  Ports    : refclk     - sole clock, rising edge
//             rst        - synchronous active-high reset
//             sync_in    - (CLKGEN_SYNC_EN only) phase re-align request
//             cfg_valid  - new configuration offered
//             cfg_ready  - configuration accepted this cycle when high
//             cfg_inc    - new accumulator increment
//             cfg_div    - new divisors, output i at [i*DIV_W +: DIV_W]
//             outclk     - derived clocks (registered)
//             outclk_en  - one-cycle strobe on each outclk rising edge
//             locked     - outputs valid and stable
//  Options  : `define CLKGEN_SYNC_EN adds the sync_in phase-align input.
//  Revision : 1.0 - initial release
// ============================================================================
module pyramic_clkgen_nco #(
    parameter int          ACC_W       = 32,
    parameter int          NUM_OUT     = 4,
    parameter int          DIV_W       = 8,
    parameter int          LOCK_CYCLES = 256,
    parameter int unsigned INC_RESET   = 1055531163,
    parameter int unsigned DIV_RESET   = 1
) (
    input  logic                     refclk,
    input  logic                     rst,
`ifdef CLKGEN_SYNC_EN
    input  logic                     sync_in,
`endif
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ACC_W-1:0]         cfg_inc,
    input  logic [NUM_OUT*DIV_W-1:0] cfg_div,
    output logic [NUM_OUT-1:0]       outclk,
    output logic [NUM_OUT-1:0]       outclk_en,
    output logic                     locked
);

    localparam int c_LOCK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        S_LOCKING = 2'd0,
        S_RUN     = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_LOCK_W-1:0]        r_lock_cnt;
    logic [ACC_W-1:0]           r_acc;
    logic [ACC_W-1:0]           r_inc;
    logic [ACC_W-1:0]           r_sh_inc;
    logic [NUM_OUT*DIV_W-1:0]   r_div;
    logic [NUM_OUT*DIV_W-1:0]   r_sh_div;
    logic [DIV_W-1:0]           r_cnt [NUM_OUT];
    logic [NUM_OUT-1:0]         r_outclk;
    logic [NUM_OUT-1:0]         r_outclk_en;
    logic [NUM_OUT-1:0]         w_wrap;
    logic [ACC_W:0]             w_sum;
    logic                       w_tick;
    logic                       w_xfer;
    logic                       w_lock_done;
    logic                       w_sync_clr;

    // Extra MSB of the sum is the accumulator carry, i.e. the base tick.
    assign w_sum       = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_tick      = w_sum[ACC_W];

    assign cfg_ready   = !rst && (r_state != S_UPDATE);
    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_lock_done = (r_lock_cnt == c_LOCK_W'(LOCK_CYCLES - 1));
    assign locked      = !rst && (r_state == S_RUN);
    assign outclk      = r_outclk;
    assign outclk_en   = r_outclk_en;

    // A divisor of zero wraps after one tick, exactly like a divisor of one.
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_wrap
        logic [DIV_W-1:0] w_div;
        logic [DIV_W-1:0] w_last;
        assign w_div      = r_div[gi*DIV_W +: DIV_W];
        assign w_last     = (w_div == '0) ? '0 : (w_div - DIV_W'(1));
        assign w_wrap[gi] = (r_cnt[gi] == w_last);
    end

`ifdef CLKGEN_SYNC_EN
    logic r_sync_q;
    logic r_sync_q2;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sync_q  <= 1'b0;
            r_sync_q2 <= 1'b0;
        end else begin
            r_sync_q  <= sync_in;
            r_sync_q2 <= r_sync_q;
        end
    end

    assign w_sync_clr = r_sync_q && !r_sync_q2 && (r_state == S_RUN);
`else
    assign w_sync_clr = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= S_LOCKING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOCKING: begin
                if (w_xfer) begin
                    w_state_nxt = S_UPDATE;
                end else if (w_lock_done) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: w_state_nxt = S_LOCKING;
            default:  w_state_nxt = S_LOCKING;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_acc       <= '0;
            r_inc       <= ACC_W'(INC_RESET);
            r_sh_inc    <= ACC_W'(INC_RESET);
            r_div       <= {NUM_OUT{DIV_W'(DIV_RESET)}};
            r_sh_div    <= {NUM_OUT{DIV_W'(DIV_RESET)}};
            r_outclk    <= '0;
            r_outclk_en <= '0;
            r_lock_cnt  <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_outclk_en <= '0;

            if (w_xfer) begin
                r_sh_inc <= cfg_inc;
                r_sh_div <= cfg_div;
            end

            case (r_state)
                S_RUN: begin
                    r_lock_cnt <= '0;
                    if (w_sync_clr) begin
                        r_acc    <= '0;
                        r_outclk <= '0;
                        for (int i = 0; i < NUM_OUT; i++) begin
                            r_cnt[i] <= '0;
                        end
                    end else begin
                        r_acc <= w_sum[ACC_W-1:0];
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (w_tick) begin
                                if (w_wrap[i]) begin
                                    r_cnt[i]       <= '0;
                                    r_outclk[i]    <= ~r_outclk[i];
                                    // Strobe only on the 0->1 transition.
                                    r_outclk_en[i] <= ~r_outclk[i];
                                end else begin
                                    r_cnt[i] <= r_cnt[i] + DIV_W'(1);
                                end
                            end
                        end
                    end
                end
                S_UPDATE: begin
                    r_inc      <= r_sh_inc;
                    r_div      <= r_sh_div;
                    r_acc      <= '0;
                    r_outclk   <= '0;
                    r_lock_cnt <= '0;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        r_cnt[i] <= '0;
                    end
                end
                default: begin
                    // LOCKING: outputs held quiet while the settle count runs.
                    r_acc      <= '0;
                    r_outclk   <= '0;
                    r_lock_cnt <= w_lock_done ? '0 : (r_lock_cnt + c_LOCK_W'(1));
                    for (int i = 0; i < NUM_OUT; i++) begin
                        r_cnt[i] <= '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pyramic_clkgen_nco.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pyramic_clkgen_nco
//  Purpose  : Directed self-checking bench for pyramic_clkgen_nco with
//             LOCK_CYCLES = 16: reset state, lock timing, handshake during
//             UPDATE, divided clock periods/strobes, divisor zero, lock
//             restart from LOCKING, reset in UPDATE and reset increment.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pyramic_clkgen_nco;

    logic        refclk    = 1'b0;
    logic        rst       = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_inc   = '0;
    logic [31:0] cfg_div   = '0;
    logic        cfg_ready;
    logic [3:0]  outclk;
    logic [3:0]  outclk_en;
    logic        locked;
`ifdef CLKGEN_SYNC_EN
    logic        sync_in   = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    pyramic_clkgen_nco #(
        .LOCK_CYCLES (16)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
`ifdef CLKGEN_SYNC_EN
        .sync_in   (sync_in),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_inc   (cfg_inc),
        .cfg_div   (cfg_div),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Offer a configuration in the current (RUN/LOCKING) cycle; returns in UPDATE.
    task automatic xfer(input logic [31:0] inc, input logic [31:0] div);
        cfg_valid = 1'b1;
        cfg_inc   = inc;
        cfg_div   = div;
        chk("xfer_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        chk("upd_ready", {31'd0, cfg_ready}, 32'd0);
        chk("upd_locked", {31'd0, locked}, 32'd0);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_lock(input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            chk("lock_timing", {31'd0, locked}, (k == n) ? 32'd1 : 32'd0);
            chk("lock_outclk", {28'd0, outclk}, 32'd0);
        end
    endtask

    // inc = 2^31 gives a base tick every second refclk. Output i with
    // effective divisor d toggles every 2*d refclk, rising first at j = 2*d.
    task automatic check_periods(input logic [3:0] d0, input logic [3:0] d1,
                                 input logic [3:0] d2, input logic [3:0] d3);
        int d [4];
        logic [3:0] eo;
        logic [3:0] ee;
        d[0] = int'(d0); d[1] = int'(d1); d[2] = int'(d2); d[3] = int'(d3);
        for (int j = 0; j < 48; j++) begin
            for (int i = 0; i < 4; i++) begin
                eo[i] = ((j / (2 * d[i])) % 2) == 1;
                ee[i] = (j % (4 * d[i])) == (2 * d[i]);
            end
            chk("period_outclk", {28'd0, outclk}, {28'd0, eo});
            chk("period_en", {28'd0, outclk_en}, {28'd0, ee});
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_outclk", {28'd0, outclk}, 32'd0);
        chk("rst_en", {28'd0, outclk_en}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);

        // Release: ready at once, locked on the 17th cycle
        rst = 1'b0;
        #1;
        chk("rel_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rel_locked", {31'd0, locked}, 32'd0);
        wait_lock(16);

        // Transfer from RUN with cfg_valid held through UPDATE
        cfg_valid = 1'b1;
        cfg_inc   = 32'h8000_0000;
        cfg_div   = 32'h0403_0201;
        chk("run_ready", {31'd0, cfg_ready}, 32'd1);
        step();
        chk("upd_ready", {31'd0, cfg_ready}, 32'd0);
        chk("upd_locked", {31'd0, locked}, 32'd0);
        cfg_inc = 32'h4000_0000;
        step();
        chk("lockng_ready", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b0;
        wait_lock(16);
        check_periods(4'd1, 4'd2, 4'd3, 4'd4);

        // Transfer during LOCKING restarts the settle count; divisor 0 == 1
        xfer(32'h8000_0000, 32'h0000_0100);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("restart_locked", {31'd0, locked}, 32'd0);
        end
        xfer(32'h8000_0000, 32'h0000_0100);
        wait_lock(17);
        check_periods(4'd1, 4'd1, 4'd1, 4'd1);

        // Reset in UPDATE discards inc = 2^30
        xfer(32'h4000_0000, 32'h0505_0505);
        rst = 1'b1;
        step();
        chk("rstupd_outclk", {28'd0, outclk}, 32'd0);
        chk("rstupd_en", {28'd0, outclk_en}, 32'd0);
        chk("rstupd_locked", {31'd0, locked}, 32'd0);
        chk("rstupd_ready", {31'd0, cfg_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rstupd_rel_ready", {31'd0, cfg_ready}, 32'd1);
        wait_lock(16);

        // Reset increment 1055531163: carries in RUN cycles 4 and 8
        for (int j = 0; j < 10; j++) begin
            chk("incrst_outclk", {28'd0, outclk}, (j >= 5 && j <= 8) ? 32'hF : 32'h0);
            chk("incrst_en", {28'd0, outclk_en}, (j == 5) ? 32'hF : 32'h0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pyramic_clkgen_nco.md
PYRAMIC_CLKGEN_NCO -- requirements
Module: pyramic_clkgen_nco

Interface
REQ-001 Parameter ACC_W, default 32, phase-accumulator width in bits.
REQ-002 Parameter NUM_OUT, default 4, number of derived output clocks.
REQ-003 Parameter DIV_W, default 8, per-output divider width.
REQ-004 Parameter LOCK_CYCLES, default 256, settle time in refclk cycles before locked asserts.
REQ-005 Parameter INC_RESET, default 1055531163, reset increment (12.288 MHz base tick from 50 MHz refclk).
REQ-006 Parameter DIV_RESET, default 1, reset divisor applied to every output.
REQ-007 refclk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 cfg_valid  in  1  new configuration offered.
REQ-010 cfg_ready  out  1  configuration can be accepted this cycle.
REQ-011 cfg_inc  in  ACC_W  new accumulator increment.
REQ-012 cfg_div  in  NUM_OUT*DIV_W  new divisors; output i at bits [i*DIV_W +: DIV_W].
REQ-013 outclk  out  NUM_OUT  derived clocks, registered, 50% duty.
REQ-014 outclk_en  out  NUM_OUT  one-cycle strobe on each outclk rising edge.
REQ-015 locked  out  1  outputs valid and stable.

Function
REQ-016 Base tick = carry out of acc + inc (ACC_W bits, wraps modulo 2^ACC_W); acc updates every RUN cycle.
REQ-017 Per output i, counter cnt_i counts base ticks; on tick with cnt_i == max(div_i,1)-1, cnt_i clears and outclk[i] toggles; otherwise cnt_i increments on tick.
REQ-018 outclk[i] period = 2*max(div_i,1) base ticks; div_i = 0 behaves as 1.
REQ-019 outclk_en[i] = 1 exactly in the cycle outclk[i] goes 0->1, same register stage (zero relative latency).
REQ-020 FSM states: LOCKING, RUN, UPDATE.
REQ-021 LOCKING: acc, cnt_i, outclk, outclk_en held 0; lock counter increments; after LOCK_CYCLES cycles go RUN.
REQ-022 RUN: locked = 1; NCO and dividers run.
REQ-023 cfg_ready = 1 in LOCKING and RUN, 0 in UPDATE and while rst is high.
REQ-024 Transfer when cfg_valid && cfg_ready: cfg_inc/cfg_div captured into shadow registers, next state UPDATE.
REQ-025 UPDATE (one cycle): shadow copied to active inc/div; acc, cnt_i, outclk, lock counter cleared; locked = 0; next LOCKING.
REQ-026 Transfer during LOCKING restarts the lock count via UPDATE.
REQ-027 locked deasserts the cycle after a RUN-state transfer and reasserts LOCK_CYCLES+1 cycles later.
REQ-028 cfg_* inputs ignored when no transfer occurs; active configuration never changes outside UPDATE.

Reset
REQ-029 While rst high: acc = 0, cnt_i = 0, outclk = 0, outclk_en = 0, locked = 0, cfg_ready = 0, inc = INC_RESET, div_i = DIV_RESET, state LOCKING, lock counter 0.
REQ-030 rst asserted mid-operation (any state, including UPDATE) overrides all; a pending shadow configuration is discarded.
REQ-031 First cycle after rst low: cfg_ready = 1; locked rises after LOCK_CYCLES cycles absent transfers.

Configuration
REQ-032 Macro CLKGEN_SYNC_EN, when defined, adds port sync_in (in, 1): registered once, rising edge detected; on detected edge in RUN, acc, cnt_i, outclk cleared next cycle, locked unaffected; edges outside RUN ignored.
REQ-033 Without CLKGEN_SYNC_EN, sync_in port and logic are absent; behaviour otherwise identical.

Verification
REQ-034 Reset release, LOCK_CYCLES=16 -> locked = 0 for 16 cycles, 1 on cycle 17; outclk all 0 until then.
REQ-035 Config inc = 2^31, div = {4,3,2,1} -> outclk[0..3] periods 4, 8, 12, 16 refclk cycles; one outclk_en pulse per period.
REQ-036 div_i = 0 -> outclk[i] period identical to div_i = 1.
REQ-037 cfg_valid held high during UPDATE -> cfg_ready = 0 for that cycle, exactly one transfer; second transfer only in following LOCKING cycle.
REQ-038 rst pulsed in UPDATE after transfer of inc = 2^30 -> post-reset inc = INC_RESET, outputs 0.
REQ-039 CLKGEN_SYNC_EN defined, sync_in 0->1 in RUN -> two cycles later outclk = 0, cnt_i = 0, locked stays 1.
